instruction_fetch_unit: RTL and testbench

//  Front end of the CPU, directly upstream of the instruction decoder/control unit.

---
 rtl/cpu_defs_pkg.sv | 15 +
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/next_pc_calc.sv | 38 +++
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions used by the fetch unit and the control unit.
//   npc_op_e : next-PC selection codes driven by the control unit
//   NOP_INSN : canonical NOP (addi x0,x0,0) shown to the decoder when nothing is fetched
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    NPC_PC4  = 2'd0,
    NPC_B    = 2'd1,
    NPC_JAL  = 2'd2,
    NPC_JALR = 2'd3
  } npc_op_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// IROM fetch bus.
//   ImemRequest  : fetch request, held until ImemReady
//   ImemAddress  : byte address of the fetch
//   ImemReady    : IROM data valid this cycle
//   ImemData     : instruction word
// master = fetch unit, slave = IROM.
interface instruction_fetch_unit_if;

  logic        ImemRequest;
  logic [31:0] ImemAddress;
  logic        ImemReady;
  logic [31:0] ImemData;

  modport master (
    output ImemRequest,
    output ImemAddress,
    input  ImemReady,
    input  ImemData
  );

  modport slave (
    input  ImemRequest,
    input  ImemAddress,
    output ImemReady,
    output ImemData
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC mux plus alignment flag.
//   pc, op, taken, imm, alu : current PC, selection code, branch condition,
//                             B/J offset, JALR target (rs1+imm)
//   npc                     : selected next PC (modulo 2^32)
//   misaligned              : npc is not 4-byte aligned
module next_pc_calc
  import cpu_defs_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  op,
  input  logic        taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu,
  output logic [31:0] npc,
  output logic        misaligned
);

  logic [31:0] pc4;
  logic [31:0] pc_rel;

  assign pc4    = pc + 32'd4;
  assign pc_rel = pc + imm;

  always_comb begin
    npc = pc4;
    case (op)
      NPC_PC4:  npc = pc4;
      NPC_B:    npc = taken ? pc_rel : pc4;
      NPC_JAL:  npc = pc_rel;
      // Only bit0 is cleared; a set bit1 survives and is caught below.
      NPC_JALR: npc = alu & ~32'h1;
      default:  npc = pc4;
    endcase
  end

  assign misaligned = |npc[1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// CPU front end: holds the PC, fetches one instruction at a time over the IROM
// req/ready bus, presents it to the decoder and advances on Retire.
//   Clock, Reset      : rising-edge clock, synchronous active-high reset
//   imem              : IROM bus (master side)
//   Instruction       : registered instruction word for the decoder
//   InstructionValid  : Instruction is current and awaiting Retire
//   ProgramCounter    : PC of Instruction
//   PcPlus4           : ProgramCounter + 4 (link value)
//   Retire            : execute is done with Instruction
//   NpcOperation      : next-PC selection (cpu_defs_pkg::npc_op_e)
//   BranchTaken       : branch condition, used for NPC_B only
//   Immediate         : sign-extended B/J offset
//   AluResult         : JALR target
//   MisalignedFault   : sticky, set when a retired next PC is misaligned
module instruction_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                             Clock,
  input  logic                             Reset,
  instruction_fetch_unit_if.master         imem,
  output logic [31:0]                      Instruction,
  output logic                             InstructionValid,
  output logic [31:0]                      ProgramCounter,
  output logic [31:0]                      PcPlus4,
  input  logic                             Retire,
  input  logic [1:0]                       NpcOperation,
  input  logic                             BranchTaken,
  input  logic [31:0]                      Immediate,
  input  logic [31:0]                      AluResult,
  output logic                             MisalignedFault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        npc_misaligned;

  next_pc_calc u_npc (
    .pc         (pc),
    .op         (NpcOperation),
    .taken      (BranchTaken),
    .imm        (Immediate),
    .alu        (AluResult),
    .npc        (npc),
    .misaligned (npc_misaligned)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state            <= S_FETCH;
      pc               <= RESET_PC;
      Instruction      <= NOP_INSN;
      InstructionValid <= 1'b0;
      MisalignedFault  <= 1'b0;
    end else begin
      case (state)
        S_FETCH, S_WAIT: begin
          if (imem.ImemReady) begin
            Instruction      <= imem.ImemData;
            InstructionValid <= 1'b1;
            state            <= S_ISSUE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_ISSUE: begin
          if (Retire) begin
            pc               <= npc;
            InstructionValid <= 1'b0;
            if (npc_misaligned) begin
              MisalignedFault <= 1'b1;
              state           <= S_HALT;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        default: begin
          // HALT: terminal until reset
          InstructionValid <= 1'b0;
        end
      endcase
    end
  end

  // Request is masked while Reset is high so an in-flight fetch is dropped
  // in the reset cycle itself rather than one cycle later.
  assign imem.ImemRequest = ((state == S_FETCH) || (state == S_WAIT)) && !Reset;
  assign imem.ImemAddress = pc;

  assign ProgramCounter = pc;
  assign PcPlus4        = pc + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import cpu_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc, pc4;
  logic        valid, fault;
  logic        retire;
  logic [1:0]  op;
  logic        taken;
  logic [31:0] imm, alu;

  int tests = 0;
  int fails = 0;

  instruction_fetch_unit_if imem_bus ();

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clock            (clk),
    .Reset            (rst),
    .imem             (imem_bus),
    .Instruction      (instr),
    .InstructionValid (valid),
    .ProgramCounter   (pc),
    .PcPlus4          (pc4),
    .Retire           (retire),
    .NpcOperation     (op),
    .BranchTaken      (taken),
    .Immediate        (imm),
    .AluResult        (alu),
    .MisalignedFault  (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wait_cyc;
    logic [31:0] data;
    logic [1:0]  op;
    logic        taken;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] exp_pc;
    logic [31:0] exp_npc;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{0, 32'h1000_006F, NPC_JAL,  1'b0, 32'h0000_0100, 32'h0,         32'h0000_0000, 32'h0000_0100, 1'b0};
    vecs[1] = '{2, 32'h0010_0093, NPC_PC4,  1'b1, 32'h0000_0040, 32'h0,         32'h0000_0100, 32'h0000_0104, 1'b0};
    vecs[2] = '{0, 32'hFFDF_F06F, NPC_JAL,  1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0104, 32'h0000_0100, 1'b0};
    vecs[3] = '{1, 32'hFE00_0CE3, NPC_B,    1'b1, 32'hFFFF_FFF8, 32'h0,         32'h0000_0100, 32'h0000_00F8, 1'b0};
    vecs[4] = '{0, 32'hFE00_0CE3, NPC_B,    1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_00F8, 32'h0000_00FC, 1'b0};
    vecs[5] = '{0, 32'h0000_80E7, NPC_JALR, 1'b0, 32'h0,         32'hFFFF_FFFD, 32'h0000_00FC, 32'hFFFF_FFFC, 1'b0};
    vecs[6] = '{3, 32'h0000_0013, NPC_PC4,  1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[7] = '{0, 32'h0000_80E7, NPC_JALR, 1'b0, 32'h0,         32'h0000_0203, 32'h0000_0000, 32'h0000_0202, 1'b1};

    rst = 1'b1; retire = 1'b0; op = NPC_PC4; taken = 1'b0; imm = '0; alu = '0;
    imem_bus.ImemReady = 1'b0; imem_bus.ImemData = '0;
    tick(); tick();

    // reset state
    chk("rst_req",   {31'b0, imem_bus.ImemRequest}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc",    pc, 32'h0);
    chk("rst_pc4",   pc4, 32'h4);

    rst = 1'b0;
    #1;
    chk("first_instr_nop", instr, 32'h0000_0013);
    chk("first_valid",     {31'b0, valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = vecs[i];
      chk($sformatf("v%0d_req", i),  {31'b0, imem_bus.ImemRequest}, 32'd1);
      chk($sformatf("v%0d_addr", i), imem_bus.ImemAddress, v.exp_pc);
      for (int c = 0; c <= v.wait_cyc; c++) begin
        if (c > 0) begin
          chk($sformatf("v%0d_wait%0d_req", i, c),   {31'b0, imem_bus.ImemRequest}, 32'd1);
          chk($sformatf("v%0d_wait%0d_addr", i, c),  imem_bus.ImemAddress, v.exp_pc);
          chk($sformatf("v%0d_wait%0d_valid", i, c), {31'b0, valid}, 32'd0);
        end
        imem_bus.ImemReady = (c == v.wait_cyc);
        imem_bus.ImemData  = (c == v.wait_cyc) ? v.data : 32'hBAD0_0000;
        tick();
      end
      imem_bus.ImemReady = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'b0, valid}, 32'd1);
      chk($sformatf("v%0d_instr", i), instr, v.data);
      chk($sformatf("v%0d_pc", i),    pc, v.exp_pc);
      chk($sformatf("v%0d_pc4", i),   pc4, v.exp_pc + 32'd4);
      chk($sformatf("v%0d_req_issue", i), {31'b0, imem_bus.ImemRequest}, 32'd0);

      // stray ready in ISSUE must be ignored; instruction held without retire
      imem_bus.ImemReady = 1'b1; imem_bus.ImemData = 32'hFFFF_FFFF;
      tick();
      imem_bus.ImemReady = 1'b0;
      chk($sformatf("v%0d_hold_instr", i), instr, v.data);
      chk($sformatf("v%0d_hold_valid", i), {31'b0, valid}, 32'd1);

      op = v.op; taken = v.taken; imm = v.imm; alu = v.alu; retire = 1'b1;
      tick();
      retire = 1'b0;
      chk($sformatf("v%0d_fault", i), {31'b0, fault}, {31'b0, v.exp_fault});
      chk($sformatf("v%0d_npc", i),   pc, v.exp_npc);
      chk($sformatf("v%0d_valid_after", i), {31'b0, valid}, 32'd0);
      if (!v.exp_fault) begin
        chk($sformatf("v%0d_next_req", i),  {31'b0, imem_bus.ImemRequest}, 32'd1);
        chk($sformatf("v%0d_next_addr", i), imem_bus.ImemAddress, v.exp_npc);
      end else begin
        chk($sformatf("v%0d_halt_req", i),  {31'b0, imem_bus.ImemRequest}, 32'd0);
      end
    end

    // HALT is terminal: ready and retire both ignored
    imem_bus.ImemReady = 1'b1; retire = 1'b1; op = NPC_PC4;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_req",   {31'b0, imem_bus.ImemRequest}, 32'd0);
      chk("halt_valid", {31'b0, valid}, 32'd0);
      chk("halt_fault", {31'b0, fault}, 32'd1);
      chk("halt_pc",    pc, 32'h0000_0202);
    end
    imem_bus.ImemReady = 1'b0; retire = 1'b0;

    // reset out of HALT, then JAL +6 from 0 faults
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("rh_fault", {31'b0, fault}, 32'd0);
    chk("rh_req",   {31'b0, imem_bus.ImemRequest}, 32'd1);
    chk("rh_addr",  imem_bus.ImemAddress, 32'h0);
    imem_bus.ImemReady = 1'b1; imem_bus.ImemData = 32'h0060_006F;
    tick();
    imem_bus.ImemReady = 1'b0;
    chk("jal6_valid", {31'b0, valid}, 32'd1);
    op = NPC_JAL; imm = 32'h6; retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("jal6_fault", {31'b0, fault}, 32'd1);
    chk("jal6_pc",    pc, 32'h6);
    chk("jal6_req",   {31'b0, imem_bus.ImemRequest}, 32'd0);

    // reset while in WAIT with a late ready: data must be dropped
    rst = 1'b1; tick(); rst = 1'b0; #1;
    imem_bus.ImemReady = 1'b0;
    tick();
    chk("w_req",   {31'b0, imem_bus.ImemRequest}, 32'd1);
    chk("w_valid", {31'b0, valid}, 32'd0);
    rst = 1'b1; imem_bus.ImemReady = 1'b1; imem_bus.ImemData = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; imem_bus.ImemReady = 1'b0;
    #1;
    chk("wr_req",   {31'b0, imem_bus.ImemRequest}, 32'd1);
    chk("wr_addr",  imem_bus.ImemAddress, 32'h0);
    chk("wr_valid", {31'b0, valid}, 32'd0);
    chk("wr_instr", instr, 32'h0000_0013);
    tick();
    chk("wr2_valid", {31'b0, valid}, 32'd0);
    chk("wr2_instr", instr, 32'h0000_0013);
    imem_bus.ImemReady = 1'b1; imem_bus.ImemData = 32'h0050_0093;
    tick();
    imem_bus.ImemReady = 1'b0;
    chk("wr3_valid", {31'b0, valid}, 32'd1);
    chk("wr3_instr", instr, 32'h0050_0093);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
